// File: rtl/tail_light_input_cond.sv
// Tail-light input conditioning: synchronizes and debounces the turn/hazard switches and
// arbitrates them into one clean request with a forced all-off gap. Option: TAIL_LIGHT_DEBOUNCE_EN.
module tail_light_input_cond #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic left_sw,
    input  logic right_sw,
    input  logic haz_sw,
    output logic left_req,
    output logic right_req,
    output logic haz_req
);

    localparam int unsigned NCH = 3;
    localparam int unsigned GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LEFT_ON, RIGHT_ON, HAZ_ON, GAP} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_LEFT, REQ_RIGHT, REQ_HAZ} req_t;

    if (DEB_CYCLES < 1 || DEB_CYCLES > 255 || GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_param
        $error("tail_light_input_cond: DEB_CYCLES and GAP_CYCLES must be in 1..255");
    end

    // Channel order everywhere: bit 0 left, bit 1 right, bit 2 hazard.
    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] deb;

    assign raw = {haz_sw, right_sw, left_sw};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef TAIL_LIGHT_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] deb_cnt [NCH];

    // Accept a new level only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb <= '0;
            for (int i = 0; i < NCH; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i] <= '0;
                    deb[i]     <= ~deb[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CW'(1);
                end
            end
        end
    end
`else
    assign deb = sync2;
`endif

    req_t req_c;

    // Hazard wins, and left+right together is treated as hazard.
    always_comb begin
        req_c = REQ_NONE;
        if (deb[2] || (deb[0] && deb[1])) req_c = REQ_HAZ;
        else if (deb[0])                  req_c = REQ_LEFT;
        else if (deb[1])                  req_c = REQ_RIGHT;
    end

    function automatic state_t on_state(input req_t r);
        case (r)
            REQ_LEFT:  return LEFT_ON;
            REQ_RIGHT: return RIGHT_ON;
            REQ_HAZ:   return HAZ_ON;
            default:   return IDLE;
        endcase
    endfunction

    state_t        state;
    state_t        state_nxt;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_nxt;

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            left_req  <= 1'b0;
            right_req <= 1'b0;
            haz_req   <= 1'b0;
        end else begin
            state     <= state_nxt;
            gap_cnt   <= gap_nxt;
            left_req  <= (state_nxt == LEFT_ON);
            right_req <= (state_nxt == RIGHT_ON);
            haz_req   <= (state_nxt == HAZ_ON);
        end
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        case (state)
            IDLE: state_nxt = on_state(req_c);
            LEFT_ON, RIGHT_ON, HAZ_ON: begin
                if (req_c == REQ_NONE) begin
                    state_nxt = IDLE;
                end else if (on_state(req_c) != state) begin
                    state_nxt = GAP;
                    gap_nxt   = GAP_LOAD;
                end
            end
            // Fixed-length blackout; the request is only looked at on the exit edge.
            GAP: begin
                if (gap_cnt == '0) state_nxt = on_state(req_c);
                else               gap_nxt   = gap_cnt - GW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tail_light_input_cond.sv
// Directed bench for tail_light_input_cond; latencies adapt to TAIL_LIGHT_DEBOUNCE_EN.
module tb_tail_light_input_cond;

    localparam int unsigned DEB = 4;
    localparam int unsigned GP  = 8;
`ifdef TAIL_LIGHT_DEBOUNCE_EN
    localparam int LAT = DEB + 3;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic left_sw = 1'b0;
    logic right_sw = 1'b0;
    logic haz_sw = 1'b0;
    logic left_req, right_req, haz_req;
    logic [2:0] outs;

    int checks = 0;
    int errors = 0;

    assign outs = {left_req, right_req, haz_req};

    always #5 clk = ~clk;

    tail_light_input_cond #(.DEB_CYCLES(DEB), .GAP_CYCLES(GP)) dut (
        .clk       (clk),
        .reset     (reset),
        .left_sw   (left_sw),
        .right_sw  (right_sw),
        .haz_sw    (haz_sw),
        .left_req  (left_req),
        .right_req (right_req),
        .haz_req   (haz_req)
    );

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got lrh=%b expected lrh=%b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input string tag, input int n, input logic [2:0] exp);
        for (int i = 0; i < n; i++) begin
            tick(1);
            check(tag, outs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset = 1'b1;
        #1 check("rst_async", outs, 3'b000);
        tick(2);
        check("rst_hold", outs, 3'b000);
        reset = 1'b0;

        // Left held from reset
        left_sw = 1'b1;
        hold("left_wait", LAT - 1, 3'b000);
        tick(1);
        check("left_on", outs, 3'b100);
        left_sw = 1'b0;
        hold("left_keep", LAT - 1, 3'b100);
        tick(1);
        check("left_off", outs, 3'b000);

`ifdef TAIL_LIGHT_DEBOUNCE_EN
        // Short glitch must be filtered
        left_sw = 1'b1;
        tick(3);
        left_sw = 1'b0;
        hold("glitch", 2 * LAT, 3'b000);
`endif

        // Left to right swap goes through the gap
        left_sw = 1'b1;
        tick(LAT);
        check("swap_left", outs, 3'b100);
        left_sw  = 1'b0;
        right_sw = 1'b1;
        hold("swap_keep", LAT - 1, 3'b100);
        tick(1);
        check("swap_gap_in", outs, 3'b000);
        hold("swap_gap", GP - 1, 3'b000);
        tick(1);
        check("swap_right", outs, 3'b010);
        right_sw = 1'b0;
        tick(LAT);
        check("right_off", outs, 3'b000);

        // Left+right from idle decodes as hazard
        left_sw  = 1'b1;
        right_sw = 1'b1;
        hold("lr_wait", LAT - 1, 3'b000);
        tick(1);
        check("lr_haz", outs, 3'b001);
        left_sw  = 1'b0;
        right_sw = 1'b0;
        tick(LAT);
        check("lr_off", outs, 3'b000);

        // Reset between edges while in hazard
        haz_sw = 1'b1;
        tick(LAT);
        check("haz_on", outs, 3'b001);
        #3 reset = 1'b1;
        #1 check("haz_rst_async", outs, 3'b000);
        tick(2);
        check("haz_rst_hold", outs, 3'b000);
        reset = 1'b0;
        hold("haz_relearn", LAT - 1, 3'b000);
        tick(1);
        check("haz_back", outs, 3'b001);
        haz_sw = 1'b0;
        tick(LAT);
        check("haz_off", outs, 3'b000);

        // Drop everything during the gap: full gap, then idle
        left_sw = 1'b1;
        tick(LAT);
        check("drop_left", outs, 3'b100);
        left_sw = 1'b0;
        haz_sw  = 1'b1;
        tick(LAT);
        check("drop_gap1", outs, 3'b000);
        tick(1);
        check("drop_gap2", outs, 3'b000);
        haz_sw = 1'b0;
        hold("drop_gap", GP - 2, 3'b000);
        tick(1);
        check("drop_exit", outs, 3'b000);
        hold("drop_idle", LAT, 3'b000);

        // Adding right while in left becomes hazard after the gap
        left_sw = 1'b1;
        tick(LAT);
        check("add_left", outs, 3'b100);
        right_sw = 1'b1;
        hold("add_keep", LAT - 1, 3'b100);
        tick(1);
        check("add_gap_in", outs, 3'b000);
        hold("add_gap", GP - 1, 3'b000);
        tick(1);
        check("add_haz", outs, 3'b001);
        left_sw  = 1'b0;
        right_sw = 1'b0;
        tick(LAT);
        check("add_off", outs, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
